// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU select codes,
// FSM state encoding and the select-legality check.
package alu_pkg;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b011;
  localparam logic [2:0] SEL_GT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Codes above SEL_GT (101-111) are reserved and retire with err.
  function automatic logic sel_legal(input logic [2:0] sel);
    return (sel <= SEL_GT);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Four-state controller that runs one register-to-register ALU command:
// read both operands, drive the ALU, then write the result back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  state_e              state_q, state_d;
  logic [2:0]          sel_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   raddr1_q, raddr2_q;
  logic [DATA_W-1:0]   op1_q, op2_q;
  logic [2:0]          alu_sel_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   result_q;
  logic                we_q, done_q, err_q;
  logic                legal;

  assign legal = sel_legal(sel_q);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      rd_q      <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      alu_sel_q <= '0;
      waddr_q   <= '0;
      res_q     <= '0;
      result_q  <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Read addresses load here so they are already stable during READ.
          if (cmd_valid) begin
            sel_q    <= cmd_sel;
            rd_q     <= cmd_rd;
            raddr1_q <= cmd_rs;
            raddr2_q <= cmd_rt;
          end
        end
        ST_READ: begin
          op1_q     <= rf_rdata1;
          op2_q     <= rf_rdata2;
          alu_sel_q <= sel_q;
        end
        ST_EXEC: begin
          waddr_q  <= rd_q;
          res_q    <= alu_result;
          we_q     <= legal && (rd_q != '0);
          done_q   <= 1'b1;
          err_q    <= ~legal;
          result_q <= legal ? alu_result : '0;
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so the handshake is closed while reset is held.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign rf_raddr1 = raddr1_q;
  assign rf_raddr2 = raddr2_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_sel   = alu_sel_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = res_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register bank and ALU around the DUT,
// with a scoreboard of expected retirements popped on every done pulse.
module tb_alu_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk, reset;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_rs, cmd_rt, cmd_rd;
  logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic              rf_we;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result, result;
  logic [2:0]        alu_sel;
  logic              done, err;
  logic              bank_init;

  alu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .done(done), .err(err), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       return 32'd5;
      2:       return 32'd7;
      5:       return 32'hFFFF_FFFF;
      6:       return 32'd1;
      10:      return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return (a > b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] regs [32];
  assign rf_rdata1  = regs[rf_raddr1];
  assign rf_rdata2  = regs[rf_raddr2];
  assign alu_result = alu_f(alu_sel, alu_op1, alu_op2);

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    logic [31:0] result;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] shadow [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push(input logic [2:0] sel, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] r;
    logic        ok;
    ok       = (sel < 3'd5);
    r        = alu_f(sel, shadow[rs], shadow[rt]);
    e.waddr  = rd;
    e.wdata  = r;
    e.we     = ok && (rd != 5'd0);
    e.err    = !ok;
    e.result = ok ? r : 32'd0;
    if (e.we) shadow[rd] = r;
    sb.push_back(e);
  endtask

  // Called at (or just after) a falling edge; returns at the falling edge in READ.
  task automatic send(input logic [2:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input bit hold, input bit exp_ret, output int waited);
    cmd_sel = sel; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (exp_ret) push(sel, rs, rt, rd);
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("err", err, e.err);
          check("rf_we", rf_we, e.we);
          if (e.we) begin
            check("rf_waddr", rf_waddr, e.waddr);
            check("rf_wdata", rf_wdata, e.wdata);
          end
          check("result", result, e.result);
        end
      end else if (rf_we) begin
        check("we_without_done", rf_we, 0);
      end
    end
  end

  initial begin
    int w;
    reset = 1'b1; bank_init = 1'b1;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bank_init = 1'b0;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_raddr1", rf_raddr1, 0);
    check("rst_raddr2", rf_raddr2, 0);
    check("rst_alu_op1", alu_op1, 0);
    check("rst_alu_op2", alu_op2, 0);
    check("rst_alu_sel", alu_sel, 0);
    reset = 1'b0;
    #1 check("ready_after_rst", cmd_ready, 1);

    // ADD r3 = r1 + r2 with cycle-by-cycle timing
    send(3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, w);
    check("c1_ready", cmd_ready, 0);
    check("c1_raddr1", rf_raddr1, 1);
    check("c1_raddr2", rf_raddr2, 2);
    @(negedge clk);
    check("c2_ready", cmd_ready, 0);
    check("c2_alu_op1", alu_op1, 5);
    check("c2_alu_op2", alu_op2, 7);
    check("c2_alu_sel", alu_sel, 2);
    @(negedge clk);
    check("c3_ready", cmd_ready, 0);
    check("c3_done", done, 1);
    @(negedge clk);
    check("c4_ready", cmd_ready, 1);
    check("c4_done_pulse", done, 0);
    drain();

    // SUB wrap and unsigned GT
    send(3'd3, 5'd10, 5'd1, 5'd4, 1'b0, 1'b1, w);  drain();
    send(3'd4, 5'd1, 5'd10, 5'd11, 1'b0, 1'b1, w); drain();
    send(3'd4, 5'd10, 5'd1, 5'd12, 1'b0, 1'b1, w); drain();
    send(3'd4, 5'd5, 5'd6, 5'd13, 1'b0, 1'b1, w);  drain();
    check("r4_sub", regs[4], 32'hFFFF_FFFE);
    check("r13_gt_unsigned", regs[13], 1);

    // rd = 0 retires without a write
    send(3'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, w);   drain();
    check("r0_zero", regs[0], 0);

    // Illegal select: ALU select still driven, err pulse, result cleared
    send(3'b110, 5'd1, 5'd2, 5'd14, 1'b0, 1'b1, w);
    @(negedge clk);
    check("illegal_alu_sel", alu_sel, 3'b110);
    drain();
    check("r14_unwritten", regs[14], 0);

    // Back-to-back dependent commands with cmd_valid held
    send(3'd2, 5'd3, 5'd1, 5'd15, 1'b1, 1'b1, w);
    send(3'd1, 5'd15, 5'd1, 5'd16, 1'b0, 1'b1, w);
    check("b2b_wait", w, 3);
    drain();
    check("r16_or", regs[16], 32'd21);

    // Reset while in EXEC aborts the command
    send(3'd2, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, w);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done", done, 0);
    check("abort_we", rf_we, 0);
    check("abort_ready_in_rst", cmd_ready, 0);
    check("abort_result", result, 0);
    reset = 1'b0;
    #1 check("abort_ready_after", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done", done, 0);
      check("post_abort_we", rf_we, 0);
    end
    check("r7_unwritten", regs[7], 0);
    send(3'd3, 5'd6, 5'd5, 5'd8, 1'b0, 1'b1, w);   drain();
    check("r8_sub_wrap", regs[8], 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
